als_spi_reader: RTL
===================

// Module: als_spi_reader
// PURPOSE
//  Generates SCLK and CS_n from the system clock and reads one 16-bit frame from the
//  Pmod ALS ADC (ADC081S021) per request; extracts the 8-bit light sample.
//  Sits between the board pins (CS_n/SCLK/MISO) and the sample consumer.
//  Contains its own SCLK divider; single clock domain; SCLK is a registered data output.
// PARAMETERS
//  SCLK_DIV      26  system clocks per SCLK period; even, >=2; half period H = SCLK_DIV/2
//  QUIET_CYCLES  5   system clocks CS_n held high after a frame before next start accepted; >=1
// PORTS
//  i_clock      in   1  system clock, all logic on rising edge
//  i_aresetn    in   1  asynchronous active-low reset
//  i_start      in   1  conversion request; sampled only in IDLE
//  i_miso       in   1  ADC serial data (SDATA)
//  o_cs_n       out  1  ADC chip select, active low
//  o_sclk       out  1  ADC serial clock, idles high
//  o_busy       out  1  high from cycle after accepted start until return to IDLE
//  o_data       out  8  last captured sample; held until next o_valid
//  o_valid      out  1  one-cycle pulse, o_data updated in the same cycle
//  o_frame_err  out  1  framing error flag, qualified by o_valid
// BEHAVIOUR
//  - Reset (async, any state): o_cs_n=1, o_sclk=1, o_busy=0, o_data=8'h00, o_valid=0,
//    o_frame_err=0, FSM=IDLE, counters=0, shift register=0. Aborts a frame with no o_valid.
//  - FSM: IDLE -> SETUP -> SHIFT -> DONE -> QUIET -> IDLE.
//  - IDLE: o_cs_n=1, o_sclk=1. i_start=1 at edge 0 -> cs_n=0, busy=1 after that edge (cycle 1), SETUP.
//  - SETUP: H cycles with cs_n=0, sclk=1. Then SHIFT.
//  - SHIFT: sclk falls at cycle 1+(2k-1)H, rises at 1+2kH, k=1..16. i_miso sampled into
//    16-bit shift reg (MSB first) on the same edge that drives o_sclk high; bit k -> frame[16-k].
//  - After 16th rising edge (cycle 1+32H): DONE for 1 cycle -> o_cs_n=1, o_sclk=1,
//    o_valid=1, o_data=frame[12:5] at cycle 2+32H.
//  - Frame format: frame[15:13] leading zeros, frame[12:5] data MSB first,
//    frame[4:1] trailing zeros, frame[0] don't-care.
//  - QUIET: QUIET_CYCLES cycles, cs_n=1, busy=1; i_start ignored. Then IDLE, busy=0.
//    i_start held high -> next frame begins on first IDLE cycle.
//  - i_start outside IDLE is dropped, not queued. i_miso ignored outside SHIFT sample edges.
//  - Divider counter width $clog2(H)+1; wraps to 0 at H-1; no free-running SCLK.
// CONFIGURATION
//  ALS_FRAME_CHECK_EN defined: o_frame_err = |frame[15:13] | |frame[4:1]; valid with o_valid,
//    held until next o_valid.
//  Not defined: no check logic; o_frame_err tied 0. Port list identical in both builds.
// TESTING  (SCLK_DIV=4 -> H=2, QUIET_CYCLES=5)
//  1 Reset asserted, no clocks -> cs_n=1, sclk=1, busy=0, data=00, valid=0, frame_err=0.
//  2 start pulse, ADC model frame 0x14A0 (data A5) -> cs_n low cycles 1..65, 16 sclk rises,
//    valid pulse cycle 66 with data=A5, busy low at cycle 72.
//  3 i_start held high 3 frames, model data 00/FF/3C -> each valid; cs_n high exactly 6 cycles
//    between frames; starts during SHIFT/QUIET ignored.
//  4 Model frame 0x94A0 (leading bit 1) -> data=A5; frame_err=1 with ALS_FRAME_CHECK_EN, 0 without.
//  5 Reset asserted after 8th sclk rise -> cs_n=1, sclk=1 immediately, no valid; after release,
//    start with data 3C -> valid at cycle 66, data=3C, frame_err=0.

Source files
------------

// File: rtl/als_spi_reader_if.sv
// Signal bundle between als_spi_reader, the ADC pins and the sample consumer.
// master = the reader itself, slave = everything around it (pins, consumer, bench).
interface als_spi_reader_if;
  logic       i_start;
  logic       i_miso;
  logic       o_cs_n;
  logic       o_sclk;
  logic       o_busy;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;

  modport master (
    input  i_start,
    input  i_miso,
    output o_cs_n,
    output o_sclk,
    output o_busy,
    output o_data,
    output o_valid,
    output o_frame_err
  );

  modport slave (
    output i_start,
    output i_miso,
    input  o_cs_n,
    input  o_sclk,
    input  o_busy,
    input  o_data,
    input  o_valid,
    input  o_frame_err
  );
endinterface

// File: rtl/als_spi_reader.sv
// Reads one 16-bit ADC081S021 frame per request and extracts the 8-bit light sample.
// Optional framing check of the zero padding bits is enabled by defining ALS_FRAME_CHECK_EN.
module als_spi_reader #(
  parameter int SCLK_DIV     = 26,
  parameter int QUIET_CYCLES = 5
) (
  input  logic             i_clock,
  input  logic             i_aresetn,
  als_spi_reader_if.master bus
);

  localparam int H       = SCLK_DIV / 2;
  localparam int DIV_W   = $clog2(H) + 1;
  localparam int QUIET_W = $clog2(QUIET_CYCLES) + 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(H - 1);
  localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);
  localparam logic [QUIET_W-1:0] QUIET_ZERO = {QUIET_W{1'b0}};
  localparam logic [QUIET_W-1:0] QUIET_ONE  = QUIET_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_QUIET = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic [3:0]         bit_q, bit_d;
  logic [15:0]        shift_q, shift_d;

  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;

  logic               div_last_s;
  logic               start_acc_s;
  logic               sclk_rise_s;
  logic               sclk_fall_s;

`ifdef ALS_FRAME_CHECK_EN
  logic               frame_err_q, frame_err_d;
  logic               unused_frame_bits;
  assign unused_frame_bits = shift_q[0];
`else
  logic               unused_frame_bits;
  assign unused_frame_bits = ^{shift_q[15:13], shift_q[4:0]};
`endif

  assign div_last_s = (div_q == DIV_LAST);

  // FSM state, SCLK divider, bit counter and frame shift register.
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_ZERO;
      quiet_q <= QUIET_ZERO;
      bit_q   <= 4'd0;
      shift_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      quiet_q <= quiet_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: half-period pacing of SCLK and MSB-first capture on each rising edge.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    quiet_d     = quiet_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    start_acc_s = 1'b0;
    sclk_rise_s = 1'b0;
    sclk_fall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d     = ST_SETUP;
          div_d       = DIV_ZERO;
          bit_d       = 4'd0;
          start_acc_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_last_s) begin
          state_d     = ST_SHIFT;
          div_d       = DIV_ZERO;
          sclk_fall_s = 1'b1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_SHIFT: begin
        if (div_last_s) begin
          div_d = DIV_ZERO;
          if (sclk_q) begin
            sclk_fall_s = 1'b1;
          end else begin
            // The edge that raises SCLK is also the MISO sample point.
            sclk_rise_s = 1'b1;
            shift_d     = {shift_q[14:0], bus.i_miso};
            bit_d       = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_QUIET;
        quiet_d = QUIET_ZERO;
        div_d   = DIV_ZERO;
        bit_d   = 4'd0;
      end
      ST_QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = ST_IDLE;
          quiet_d = QUIET_ZERO;
        end else begin
          quiet_d = quiet_q + QUIET_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = DIV_ZERO;
        quiet_d = QUIET_ZERO;
        bit_d   = 4'd0;
      end
    endcase
  end

  // Output decode; everything is registered so the pins never see combinational glitches.
  always_comb begin
    // busy lags the return to IDLE by one cycle so it covers the whole quiet gap.
    busy_d  = start_acc_s | (state_q != ST_IDLE);
    valid_d = (state_q == ST_DONE);
    case (state_d)
      ST_SETUP, ST_SHIFT, ST_DONE: cs_n_d = 1'b0;
      default:                     cs_n_d = 1'b1;
    endcase
    if (sclk_fall_s) begin
      sclk_d = 1'b0;
    end else if (sclk_rise_s) begin
      sclk_d = 1'b1;
    end else if (state_d == ST_SHIFT) begin
      sclk_d = sclk_q;
    end else begin
      sclk_d = 1'b1;
    end
    if (state_q == ST_DONE) begin
      data_d = shift_q[12:5];
    end else begin
      data_d = data_q;
    end
`ifdef ALS_FRAME_CHECK_EN
    if (state_q == ST_DONE) begin
      frame_err_d = (|shift_q[15:13]) | (|shift_q[4:1]);
    end else begin
      frame_err_d = frame_err_q;
    end
`endif
  end

  // Registered pin and consumer outputs.
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
`ifdef ALS_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
`ifdef ALS_FRAME_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign bus.o_cs_n  = cs_n_q;
  assign bus.o_sclk  = sclk_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
`ifdef ALS_FRAME_CHECK_EN
  assign bus.o_frame_err = frame_err_q;
`else
  assign bus.o_frame_err = 1'b0;
`endif

endmodule
